// File: rtl/frame_renderer_if.sv
// frame_renderer_if: bundles the renderer's control handshake, game-state inputs
// and VGA-adapter pixel outputs. The master drives start, positions, grids and
// health, and the slave (the renderer) drives the pixel stream and status.
interface frame_renderer_if;
  logic           start;
  logic [7:0]     user_x;
  logic [6:0]     user_y;
  logic [7:0]     enemy_x;
  logic [6:0]     enemy_y;
  logic [19199:0] user_grid;
  logic [19199:0] enem_grid;
  logic [3:0]     ship_health;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output start, user_x, user_y, enemy_x, enemy_y, user_grid, enem_grid, ship_health,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, user_x, user_y, enemy_x, enemy_y, user_grid, enem_grid, ship_health,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_renderer.sv
// frame_renderer: on each start pulse, rasters the full screen one pixel per clock
// into the VGA adapter (x fastest), colouring ships, bullets and background by
// priority, then pulses done for one cycle.
// Optional feature macro RENDER_HEALTH_BAR_EN: row 0 becomes a health bar whose
// length is 4 pixels per health point, latched at start.
module frame_renderer #(
  parameter int          SCREEN_W       = 160,
  parameter int          SCREEN_H       = 120,
  parameter int          SHIP_W         = 8,
  parameter int          SHIP_H         = 4,
  parameter logic [2:0]  BG_COLOUR      = 3'b000,
  parameter logic [2:0]  USER_COLOUR    = 3'b010,
  parameter logic [2:0]  ENEMY_COLOUR   = 3'b100,
  parameter logic [2:0]  UBULLET_COLOUR = 3'b110,
  parameter logic [2:0]  EBULLET_COLOUR = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  frame_renderer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_xCnt;
  logic [6:0]  r_yCnt;
  logic [7:0]  r_userX;
  logic [6:0]  r_userY;
  logic [7:0]  r_enemyX;
  logic [6:0]  r_enemyY;

  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;
  logic        r_busy;
  logic        r_done;

  logic        w_plotNext;
  logic        w_busyNext;
  logic        w_doneNext;
  logic        w_advance;
  logic        w_capture;
  logic        w_lastPixel;

  logic [7:0]  w_ux;
  logic [6:0]  w_uy;
  logic [7:0]  w_ex;
  logic [6:0]  w_ey;
  logic        w_userHit;
  logic        w_enemyHit;
  logic [14:0] w_bitIdx;
  logic [2:0]  w_pixColour;

`ifdef RENDER_HEALTH_BAR_EN
  logic [3:0]  r_health;
  logic [3:0]  w_hp;
  logic [7:0]  w_barLen;
`else
  logic        w_unusedHealth;
  assign w_unusedHealth = ^bus.ship_health;
`endif

  // The pixel on the output registers is the last one of the frame.
  assign w_lastPixel = r_plot && (r_x == 8'(SCREEN_W - 1)) && (r_y == 7'(SCREEN_H - 1));

  // The first pixel is coloured in the same cycle the snapshot is taken, so it
  // must look at the live positions; every later pixel uses the snapshot.
  assign w_ux = (r_state == IDLE) ? bus.user_x  : r_userX;
  assign w_uy = (r_state == IDLE) ? bus.user_y  : r_userY;
  assign w_ex = (r_state == IDLE) ? bus.enemy_x : r_enemyX;
  assign w_ey = (r_state == IDLE) ? bus.enemy_y : r_enemyY;

  // Hit tests are widened by one bit so sprites near the edge clip instead of wrapping.
  assign w_userHit  = ({1'b0, r_xCnt} >= {1'b0, w_ux}) && ({1'b0, r_xCnt} < ({1'b0, w_ux} + 9'(SHIP_W)))
                   && ({1'b0, r_yCnt} >= {1'b0, w_uy}) && ({1'b0, r_yCnt} < ({1'b0, w_uy} + 8'(SHIP_H)));
  assign w_enemyHit = ({1'b0, r_xCnt} >= {1'b0, w_ex}) && ({1'b0, r_xCnt} < ({1'b0, w_ex} + 9'(SHIP_W)))
                   && ({1'b0, r_yCnt} >= {1'b0, w_ey}) && ({1'b0, r_yCnt} < ({1'b0, w_ey} + 8'(SHIP_H)));

  assign w_bitIdx = (15'(r_yCnt) * 15'(SCREEN_W)) + 15'(r_xCnt);

`ifdef RENDER_HEALTH_BAR_EN
  assign w_hp     = (r_state == IDLE) ? bus.ship_health : r_health;
  assign w_barLen = {2'b00, w_hp, 2'b00};
`endif

  // Priority colour of the pixel addressed by the scan counters.
  always_comb begin
    w_pixColour = BG_COLOUR;
    if (w_userHit) begin
      w_pixColour = USER_COLOUR;
    end else if (w_enemyHit) begin
      w_pixColour = ENEMY_COLOUR;
    end else if (bus.enem_grid[w_bitIdx]) begin
      w_pixColour = EBULLET_COLOUR;
    end else if (bus.user_grid[w_bitIdx]) begin
      w_pixColour = UBULLET_COLOUR;
    end
`ifdef RENDER_HEALTH_BAR_EN
    if (r_yCnt == 7'd0) begin
      w_pixColour = (r_xCnt < w_barLen) ? USER_COLOUR : BG_COLOUR;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = DRAW;
      DRAW:    if (w_lastPixel) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered strobes and datapath enables.
  always_comb begin
    w_plotNext = 1'b0;
    w_busyNext = 1'b0;
    w_doneNext = 1'b0;
    w_advance  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_plotNext = 1'b1;
          w_busyNext = 1'b1;
          w_advance  = 1'b1;
          w_capture  = 1'b1;
        end
      end
      DRAW: begin
        if (w_lastPixel) begin
          w_doneNext = 1'b1;
        end else begin
          w_plotNext = 1'b1;
          w_busyNext = 1'b1;
          w_advance  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: position snapshot, raster counters and registered VGA outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xCnt   <= '0;
      r_yCnt   <= '0;
      r_userX  <= '0;
      r_userY  <= '0;
      r_enemyX <= '0;
      r_enemyY <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= BG_COLOUR;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= w_plotNext;
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
      if (w_capture) begin
        r_userX  <= bus.user_x;
        r_userY  <= bus.user_y;
        r_enemyX <= bus.enemy_x;
        r_enemyY <= bus.enemy_y;
      end
      if (w_advance) begin
        r_x      <= r_xCnt;
        r_y      <= r_yCnt;
        r_colour <= w_pixColour;
        if (r_xCnt == 8'(SCREEN_W - 1)) begin
          r_xCnt <= '0;
          r_yCnt <= (r_yCnt == 7'(SCREEN_H - 1)) ? 7'd0 : r_yCnt + 7'd1;
        end else begin
          r_xCnt <= r_xCnt + 8'd1;
        end
      end else begin
        r_x      <= '0;
        r_y      <= '0;
        r_colour <= BG_COLOUR;
      end
    end
  end

`ifdef RENDER_HEALTH_BAR_EN
  // Health snapshot taken alongside the ship positions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_health <= '0;
    end else if (w_capture) begin
      r_health <= bus.ship_health;
    end
  end
`endif

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: directed frames with a pixel scoreboard. Expected pixels are
// queued from a reference colour model when start is driven and popped as the
// renderer plots them; frame timing and selected pixels are also checked directly.
module tb_frame_renderer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pixel_t     expQ [$];
  logic [2:0] seen [0:19199];

  frame_renderer_if bus ();

  frame_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One counted comparison; a miscompare is reported and the run carries on.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference colour of one pixel from plain integer geometry.
  function automatic logic [2:0] modelColour(input int px, input int py, input int ux, input int uy,
                                              input int ex, input int ey, input int hp);
`ifdef RENDER_HEALTH_BAR_EN
    if (py == 0) return (px < 4 * hp) ? 3'b010 : 3'b000;
`else
    if (hp < 0) return 3'b111;
`endif
    if (px >= ux && px < ux + 8 && py >= uy && py < uy + 4) return 3'b010;
    if (px >= ex && px < ex + 8 && py >= ey && py < ey + 4) return 3'b100;
    if (bus.enem_grid[py * 160 + px]) return 3'b101;
    if (bus.user_grid[py * 160 + px]) return 3'b110;
    return 3'b000;
  endfunction

  // Queue the whole expected frame from the inputs present at start.
  task automatic pushFrame();
    for (int py = 0; py < 120; py++) begin
      for (int px = 0; px < 160; px++) begin
        expQ.push_back({8'(px), 7'(py),
                        modelColour(px, py, int'(bus.user_x), int'(bus.user_y),
                                    int'(bus.enemy_x), int'(bus.enemy_y), int'(bus.ship_health))});
      end
    end
  endtask

  // Pulse start and follow the frame cycle by cycle; optional extra start,
  // user_x change and mid-frame reset at the given cycle numbers (0 = none).
  task automatic applyStimulus(input int midStartCyc, input int changeCyc,
                               input logic [7:0] newUserX, input int resetCyc);
    int plotCount;
    int doneCount;
    int doneCyc;
    int firstPlot;
    int lastPlot;
    int busyErrs;
    int strayOut;
    int idx;
    pixel_t e;
    plotCount = 0;
    doneCount = 0;
    doneCyc   = 0;
    firstPlot = 0;
    lastPlot  = 0;
    busyErrs  = 0;
    strayOut  = 0;
    pushFrame();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 19205; cyc++) begin
      if (bus.plot) begin
        plotCount++;
        if (firstPlot == 0) firstPlot = cyc;
        lastPlot = cyc;
        if (expQ.size() == 0) begin
          checkOutput("queueUnderflow", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("pixel", {14'd0, bus.x, bus.y, bus.colour}, {14'd0, e.x, e.y, e.colour});
          idx = int'(bus.y) * 160 + int'(bus.x);
          if (idx < 19200) seen[idx] = bus.colour;
        end
      end
      if (bus.done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (bus.busy !== ((cyc <= 19200) ? 1'b1 : 1'b0)) busyErrs++;
      if (cyc == resetCyc) begin
        reset = 1'b0;
        #1;
        checkOutput("resetAbortOutputs", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          if (bus.plot || bus.busy || bus.done) strayOut++;
        end
        checkOutput("resetHeldQuiet", 32'(strayOut), 32'd0);
        checkOutput("resetFrameDone", 32'(doneCount), 32'd0);
        checkOutput("resetFrameBusy", 32'(busyErrs), 32'd0);
        reset = 1'b1;
        expQ.delete();
        @(negedge clk);
        return;
      end
      bus.start = (cyc == midStartCyc) ? 1'b1 : 1'b0;
      if (cyc == changeCyc) bus.user_x = newUserX;
      @(negedge clk);
    end
    checkOutput("plotCount", 32'(plotCount), 32'd19200);
    checkOutput("firstPlotCycle", 32'(firstPlot), 32'd1);
    checkOutput("lastPlotCycle", 32'(lastPlot), 32'd19200);
    checkOutput("doneCount", 32'(doneCount), 32'd1);
    checkOutput("doneCycle", 32'(doneCyc), 32'd19201);
    checkOutput("busyWindow", 32'(busyErrs), 32'd0);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.user_x      = 8'd0;
    bus.user_y      = 7'd0;
    bus.enemy_x     = 8'd100;
    bus.enemy_y     = 7'd50;
    bus.user_grid   = '0;
    bus.enem_grid   = '0;
    bus.ship_health = 4'd5;
    repeat (3) @(negedge clk);
    checkOutput("resetState", {14'd0, bus.x, bus.y, bus.colour}, 32'd0);
    checkOutput("resetStrobes", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] frame A: ships at (0,0)/(100,50), overlapping bullets at (20,30)");
    bus.user_grid[30 * 160 + 20] = 1'b1;
    bus.enem_grid[30 * 160 + 20] = 1'b1;
    bus.user_grid[31 * 160 + 20] = 1'b1;
    applyStimulus(0, 0, 8'd0, 0);
    checkOutput("A_px0_0", 32'(seen[0]), 32'h2);
    checkOutput("A_px100_50", 32'(seen[50 * 160 + 100]), 32'h4);
    checkOutput("A_px50_100", 32'(seen[100 * 160 + 50]), 32'h0);
    checkOutput("A_px20_30", 32'(seen[30 * 160 + 20]), 32'h5);
    checkOutput("A_px20_31", 32'(seen[31 * 160 + 20]), 32'h6);
    checkOutput("A_idleAfter", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);

    $display("[TB] frame B: user at (156,118), enemy at (30,0), restart and move mid-frame");
    bus.user_grid = '0;
    bus.enem_grid = '0;
    bus.user_x    = 8'd156;
    bus.user_y    = 7'd118;
    bus.enemy_x   = 8'd30;
    bus.enemy_y   = 7'd0;
    applyStimulus(5000, 6000, 8'd10, 0);
    checkOutput("B_px156_118", 32'(seen[118 * 160 + 156]), 32'h2);
    checkOutput("B_px159_119", 32'(seen[119 * 160 + 159]), 32'h2);
    checkOutput("B_px0_118", 32'(seen[118 * 160]), 32'h0);
    checkOutput("B_px0_119", 32'(seen[119 * 160]), 32'h0);
    checkOutput("B_px10_118", 32'(seen[118 * 160 + 10]), 32'h0);
    checkOutput("B_px20_0", 32'(seen[20]), 32'h0);
`ifdef RENDER_HEALTH_BAR_EN
    checkOutput("B_px30_0", 32'(seen[30]), 32'h0);
    checkOutput("B_px19_0", 32'(seen[19]), 32'h2);
`else
    checkOutput("B_px30_0", 32'(seen[30]), 32'h4);
    checkOutput("B_px19_0", 32'(seen[19]), 32'h0);
`endif

    $display("[TB] frame C: reset mid-frame at cycle 8000");
    bus.user_x = 8'd156;
    applyStimulus(0, 0, 8'd0, 8000);

    $display("[TB] frame D: out-of-range user ship, enemy clipped at (152,116)");
    bus.user_x  = 8'd200;
    bus.user_y  = 7'd125;
    bus.enemy_x = 8'd152;
    bus.enemy_y = 7'd116;
    applyStimulus(0, 0, 8'd0, 0);
    checkOutput("D_px152_116", 32'(seen[116 * 160 + 152]), 32'h4);
    checkOutput("D_px159_119", 32'(seen[119 * 160 + 159]), 32'h4);
    checkOutput("D_px0_116", 32'(seen[116 * 160]), 32'h0);
`ifdef RENDER_HEALTH_BAR_EN
    checkOutput("D_px0_0", 32'(seen[0]), 32'h2);
`else
    checkOutput("D_px0_0", 32'(seen[0]), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
